// File: rtl/coffee_pkg.sv
// coffee_pkg: shared states, ingredient/type codes and default recipe table
package coffee_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, DONE} state_e;
    localparam logic [2:0] ING_COFFEE = 3'd0;
    localparam logic [2:0] ING_WATER  = 3'd1;
    localparam logic [2:0] ING_MILK   = 3'd2;
    localparam logic [2:0] ING_FOAM   = 3'd3;
    localparam logic [2:0] ING_CHOC   = 3'd4;
    localparam logic [2:0] T_ESPRESSO  = 3'd0;
    localparam logic [2:0] T_AMERICANO = 3'd1;
    localparam logic [2:0] T_LATTE     = 3'd2;
    localparam logic [2:0] T_MOCHA     = 3'd3;
    localparam int DEF_TYPES = 4;
    localparam int DEF_STEPS = 4;
    typedef struct packed {
        logic [2:0] ing;
        logic [3:0] dur;
    } recipe_t;
    // dur == 0 terminates a recipe
    localparam recipe_t NONE = '{ING_COFFEE, 4'd0};
    localparam recipe_t RECIPES [DEF_TYPES][DEF_STEPS] = '{
        '{'{ING_COFFEE, 4'd4}, NONE, NONE, NONE},
        '{'{ING_COFFEE, 4'd4}, '{ING_WATER, 4'd6}, NONE, NONE},
        '{'{ING_COFFEE, 4'd4}, '{ING_MILK, 4'd6}, '{ING_FOAM, 4'd3}, NONE},
        '{'{ING_COFFEE, 4'd4}, '{ING_CHOC, 4'd3}, '{ING_MILK, 4'd5}, '{ING_FOAM, 4'd2}}
    };
    function automatic recipe_t recipe_lookup(input logic [7:0] t, input logic [7:0] s);
        return (t < 8'(DEF_TYPES) && s < 8'(DEF_STEPS)) ? RECIPES[t[1:0]][s[1:0]] : NONE;
    endfunction
endpackage

// File: rtl/coffee_recipe_rom.sv
// coffee_recipe_rom: combinational (type, step) -> (ingredient, duration) lookup
module coffee_recipe_rom
    import coffee_pkg::*;
#(
    parameter int NUM_TYPES = 4,
    parameter int MAX_STEPS = 4,
    parameter int NUM_ING   = 5,
    parameter int DUR_W     = 4,
    localparam int TW = NUM_TYPES > 1 ? $clog2(NUM_TYPES) : 1,
    localparam int SW = $clog2(MAX_STEPS) + 1,
    localparam int IW = NUM_ING > 1 ? $clog2(NUM_ING) : 1
) (
    input  logic [TW-1:0]    typ,
    input  logic [SW-1:0]    step,
    output logic [IW-1:0]    ing,
    output logic [DUR_W-1:0] dur
);
    recipe_t e;
    assign e   = (32'(typ) < NUM_TYPES && 32'(step) < MAX_STEPS) ? recipe_lookup(8'(typ), 8'(step)) : NONE;
    assign ing = IW'(e.ing);
    assign dur = DUR_W'(e.dur);
endmodule

// File: rtl/coffee_sequencer.sv
// coffee_sequencer: recipe-driven valve sequencer with internal step timer, abort and status pulses
module coffee_sequencer
    import coffee_pkg::*;
#(
    parameter int NUM_TYPES = 4,
    parameter int TYPE_W    = 3,
    parameter int NUM_ING   = 5,
    parameter int MAX_STEPS = 4,
    parameter int DUR_W     = 4,
    parameter int TICK_DIV  = 1,
    localparam int IW  = NUM_ING > 1 ? $clog2(NUM_ING) : 1,
    localparam int SIW = MAX_STEPS > 1 ? $clog2(MAX_STEPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ok,
    input  logic [TYPE_W-1:0] c_type,
    input  logic              abort,
    output logic [NUM_ING-1:0] ingredientes,
    output logic [IW-1:0]     ing_type,
    output logic              start_timer,
    output logic [SIW-1:0]    step_idx,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              aborted
);
    localparam int RTW = NUM_TYPES > 1 ? $clog2(NUM_TYPES) : 1;
    // one spare bit so step can reach MAX_STEPS and end the recipe
    localparam int SW  = $clog2(MAX_STEPS) + 1;
    localparam int CW  = DUR_W + $clog2(TICK_DIV);
    state_e            state;
    logic              ok_q;
    logic [TYPE_W-1:0] typ;
    logic [SW-1:0]     step;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     ing;
    logic [IW-1:0]     rom_ing;
    logic [DUR_W-1:0]  rom_dur;
    logic              start;
    logic              valid;
    coffee_recipe_rom #(
        .NUM_TYPES(NUM_TYPES),
        .MAX_STEPS(MAX_STEPS),
        .NUM_ING(NUM_ING),
        .DUR_W(DUR_W)
    ) u_rom (
        .typ(typ[RTW-1:0]),
        .step(step),
        .ing(rom_ing),
        .dur(rom_dur)
    );
    assign start        = ok & ~ok_q;
    assign valid        = 32'(c_type) < NUM_TYPES;
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign ingredientes = state == DISPENSE ? NUM_ING'(1) << ing : '0;
    assign ing_type     = state == DISPENSE ? ing : '0;
    assign step_idx     = step[SIW-1:0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ok_q        <= 1'b0;
            typ         <= '0;
            step        <= '0;
            cnt         <= '0;
            ing         <= '0;
            start_timer <= 1'b0;
            error       <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            ok_q        <= ok;
            error       <= state == IDLE && start && !valid;
            aborted     <= state != IDLE && abort;
            start_timer <= 1'b0;
            if (abort && state != IDLE) state <= IDLE;
            else case (state)
                IDLE: if (start && valid) begin
                    typ   <= c_type;
                    step  <= '0;
                    state <= LOAD;
                end
                LOAD: if (rom_dur != '0 && 32'(step) < MAX_STEPS) begin
                    cnt         <= CW'(rom_dur) * CW'(TICK_DIV) - CW'(1);
                    ing         <= rom_ing;
                    start_timer <= 1'b1;
                    state       <= DISPENSE;
                end else state <= DONE;
                DISPENSE: if (cnt == '0) begin
                    step  <= step + SW'(1);
                    state <= LOAD;
                end else cnt <= cnt - CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coffee_sequencer.sv
// tb_coffee_sequencer: directed checks of recipe timing, error, abort, retrigger and reset behaviour
module tb_coffee_sequencer;
    logic       clk = 1'b0;
    logic       reset, ok, abort;
    logic [2:0] c_type;
    logic [4:0] ingredientes, s_ingredientes;
    logic [2:0] ing_type, s_ing_type;
    logic [1:0] step_idx, s_step_idx;
    logic       start_timer, busy, done, error, aborted;
    logic       s_start_timer, s_busy, s_done, s_error, s_aborted;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    coffee_sequencer #(.TICK_DIV(1)) u_dut (
        .clk(clk), .reset(reset), .ok(ok), .c_type(c_type), .abort(abort),
        .ingredientes(ingredientes), .ing_type(ing_type), .start_timer(start_timer),
        .step_idx(step_idx), .busy(busy), .done(done), .error(error), .aborted(aborted)
    );

    coffee_sequencer #(.TICK_DIV(3)) u_slow (
        .clk(clk), .reset(reset), .ok(ok), .c_type(c_type), .abort(abort),
        .ingredientes(s_ingredientes), .ing_type(s_ing_type), .start_timer(s_start_timer),
        .step_idx(s_step_idx), .busy(s_busy), .done(s_done), .error(s_error), .aborted(s_aborted)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // waits (bounded) for idle, drops ok for a cycle, then raises it: caller is in cycle 0
    task automatic start_run(input logic [2:0] t);
        ok = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        tick();
        c_type = t;
        ok = 1'b1;
    endtask

    function automatic int latte_ing(input int k);
        return (k >= 2 && k <= 5) ? 1 : (k >= 7 && k <= 12) ? 4 : (k >= 14 && k <= 16) ? 8 : 0;
    endfunction

    initial begin
        int restarted, seen_done, on_cnt, first_on, last_on, done_at;
        reset = 1'b0; ok = 1'b0; abort = 1'b0; c_type = 3'd0;
        repeat (3) tick();
        check("rst_ing", int'(ingredientes), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_timer", int'(start_timer), 0);
        check("rst_step", int'(step_idx), 0);
        reset = 1'b1;
        tick();

        start_run(3'd2);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            check($sformatf("latte_ing_c%0d", k), int'(ingredientes), latte_ing(k));
            check($sformatf("latte_st_c%0d", k), int'(start_timer), (k == 2 || k == 7 || k == 14) ? 1 : 0);
            check($sformatf("latte_done_c%0d", k), int'(done), k == 18 ? 1 : 0);
            check($sformatf("latte_busy_c%0d", k), int'(busy), (k >= 1 && k <= 18) ? 1 : 0);
            if (k == 8) begin
                check("latte_type_c8", int'(ing_type), 2);
                check("latte_step_c8", int'(step_idx), 1);
            end
        end

        start_run(3'd5);
        tick();
        check("inv_error", int'(error), 1);
        check("inv_busy", int'(busy), 0);
        tick();
        check("inv_error_pulse", int'(error), 0);
        check("inv_busy2", int'(busy), 0);
        check("inv_ing", int'(ingredientes), 0);

        start_run(3'd3);
        repeat (8) tick();
        check("abort_choc_on", int'(ingredientes), 16);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_ing", int'(ingredientes), 0);
        check("abort_pulse", int'(aborted), 1);
        check("abort_timer", int'(start_timer), 0);
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_pulse_end", int'(aborted), 0);

        start_run(3'd0);
        restarted = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 7) check("retrig_done", int'(done), 1);
            if (k >= 8 && busy) restarted = 1;
        end
        check("retrig_held_ok", restarted, 0);
        ok = 1'b0;
        tick();
        ok = 1'b1;
        tick();
        check("retrig_busy_c1", int'(busy), 1);
        check("retrig_ing_c1", int'(ingredientes), 0);
        tick();
        check("retrig_coffee_c2", int'(ingredientes), 1);

        start_run(3'd1);
        repeat (9) tick();
        check("rstmid_water", int'(ingredientes), 2);
        #2 reset = 1'b0; ok = 1'b0;
        #1;
        check("rstmid_ing", int'(ingredientes), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_type", int'(ing_type), 0);
        check("rstmid_step", int'(step_idx), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("rstmid_idle", int'(busy), 0);
        ok = 1'b1;
        tick();
        check("rstmid_restart", int'(busy), 1);

        ok = 1'b0; reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        c_type = 3'd0;
        ok = 1'b1;
        on_cnt = 0; first_on = -1; last_on = -1; done_at = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            if (s_ingredientes == 5'd1) begin
                on_cnt++;
                if (first_on < 0) first_on = k;
                last_on = k;
            end
            if (s_done) done_at = k;
        end
        check("div3_on_cycles", on_cnt, 12);
        check("div3_first_on", first_on, 2);
        check("div3_last_on", last_on, 13);
        check("div3_done_at", done_at, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
